// File: rtl/data_mem_lsu_if.sv
// Request/response and data-memory port bundle for the load/store unit.
// slave = the LSU itself, master = the CPU/memory environment driving it.
interface data_mem_lsu_if #(
  parameter int AW = 11
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_error;
  logic [31:0]   resp_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_error, resp_rdata, mem_en, mem_we, mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_error, resp_rdata, mem_en, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit for a 2^AW x 32 byte-enabled data memory with 1-cycle read.
// Byte offset 0 is the most significant lane; bad requests are answered without a memory access.
//
//   state     | meaning
//   IDLE      | ready for a request; error responses are issued from here
//   ACCESS    | mem_en asserted for one cycle (write or read launch)
//   LOAD_WAIT | read data on mem_rd, lane-select and extend into resp_rdata
module data_mem_lsu #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          AW        = 11
) (
  input logic          clk,
  input logic          rst_n,
  data_mem_lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, LOAD_WAIT} state_t;

  localparam logic [31:0] WINDOW = 32'd4 << AW;

  state_t      state;
  logic        acc_write;
  logic        acc_signed;
  logic [1:0]  acc_size;
  logic [1:0]  acc_lane;

  logic [31:0] offset;
  logic        req_err;
  logic [3:0]  lane_we;
  logic [31:0] lane_wd;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign bus.req_ready = (state == IDLE);
  assign offset        = bus.req_addr - BASE_ADDR;

  // Unsigned compare: addresses below BASE_ADDR wrap to huge offsets and fail.
  always_comb begin
    req_err = (offset >= WINDOW);
    case (bus.req_size)
      2'd1:    if (bus.req_addr[0]) req_err = 1'b1;
      2'd2:    if (bus.req_addr[1:0] != 2'd0) req_err = 1'b1;
      2'd3:    req_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (bus.req_size)
      2'd0: begin
        lane_we = 4'b0001 << bus.req_addr[1:0];
        lane_wd = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        lane_we = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        lane_we = 4'b1111;
        lane_wd = bus.req_wdata;
      end
    endcase
  end

  always_comb begin
    case (acc_lane)
      2'd0:    ld_byte = bus.mem_rd[31:24];
      2'd1:    ld_byte = bus.mem_rd[23:16];
      2'd2:    ld_byte = bus.mem_rd[15:8];
      default: ld_byte = bus.mem_rd[7:0];
    endcase
    ld_half = acc_lane[1] ? bus.mem_rd[15:0] : bus.mem_rd[31:16];
    case (acc_size)
      2'd0:    load_data = {{24{acc_signed & ld_byte[7]}}, ld_byte};
      2'd1:    load_data = {{16{acc_signed & ld_half[15]}}, ld_half};
      default: load_data = bus.mem_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc_write      <= 1'b0;
      acc_signed     <= 1'b0;
      acc_size       <= 2'd0;
      acc_lane       <= 2'd0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 4'd0;
      bus.mem_addr   <= '0;
      bus.mem_wd     <= 32'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_error <= 1'b0;
      bus.resp_rdata <= 32'd0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_error <= 1'b0;
      bus.resp_rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (req_err) begin
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b1;
            end else begin
              state        <= ACCESS;
              acc_write    <= bus.req_write;
              acc_signed   <= bus.req_signed;
              acc_size     <= bus.req_size;
              acc_lane     <= bus.req_addr[1:0];
              bus.mem_en   <= 1'b1;
              bus.mem_we   <= bus.req_write ? lane_we : 4'd0;
              bus.mem_addr <= offset[AW+1:2];
              bus.mem_wd   <= lane_wd;
            end
          end
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 4'd0;
          if (acc_write) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b1;
          end else begin
            state <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= load_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized and directed bench for data_mem_lsu against a word-array reference model
// and a behavioural byte-enabled memory with one-cycle registered read.
module tb_data_mem_lsu;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          AW   = 11;
  localparam int          DEPTH = 2048;

  logic clk;
  logic rst_n;
  logic load_mem;
  int   n_checks;
  int   n_fails;

  logic [31:0] tmem    [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  data_mem_lsu_if #(.AW(AW)) bus ();

  data_mem_lsu #(.BASE_ADDR(BASE), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) tmem[i] <= ref_mem[i];
    end else if (bus.mem_en) begin
      for (int k = 0; k < 4; k++)
        if (bus.mem_we[k]) tmem[bus.mem_addr][31-8*k -: 8] <= bus.mem_wd[31-8*k -: 8];
      bus.mem_rd <= tmem[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input int b, input int sz, input bit sg);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * (3 - b))) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> (16 * (1 - b / 2))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic run_req(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic [3:0] got_we, output logic [31:0] got_wd);
    logic [31:0] off, ewd, erd;
    logic [3:0]  ewe;
    bit          err, saw_en;
    int          b, idx, lat, cyc, szi;
    off = addr - BASE;
    b   = int'(addr[1:0]);
    szi = int'(sz);
    idx = int'(off >> 2);
    err = (off >= 32'd8192) || (szi == 1 && addr[0]) || (szi == 2 && b != 0) || szi == 3;
    if (szi == 0) begin
      ewe = 4'b0001 << b;
      ewd = (wd & 32'hFF) * 32'h0101_0101;
    end else if (szi == 1) begin
      ewe = (b == 0) ? 4'b0011 : 4'b1100;
      ewd = (wd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      ewe = 4'b1111;
      ewd = wd;
    end
    erd = 32'd0;
    if (!err && !wr) erd = model_load(ref_mem[idx], b, szi, sg);
    lat = err ? 1 : (wr ? 2 : 3);
    got_we = 4'd0;
    got_wd = 32'd0;

    @(negedge clk);
    check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc    = 1;
    saw_en = 1'b0;
    while (!bus.resp_valid && cyc < 10) begin
      if (bus.mem_en) begin
        saw_en = 1'b1;
        got_we = bus.mem_we;
        got_wd = bus.mem_wd;
        check("acc_addr", {21'd0, bus.mem_addr}, idx[31:0]);
        check("acc_we", {28'd0, bus.mem_we}, wr ? {28'd0, ewe} : 32'd0);
        if (wr) check("acc_wd", bus.mem_wd, ewd);
      end
      check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    rd = bus.resp_rdata;
    check("latency", cyc, lat);
    check("resp_error", {31'd0, bus.resp_error}, {31'd0, err});
    check("resp_rdata", bus.resp_rdata, erd);
    check("mem_en_seen", {31'd0, saw_en}, {31'd0, !err});
    check("en_at_resp", {31'd0, bus.mem_en}, 32'd0);
    if (!err && wr)
      for (int k = 0; k < 4; k++)
        if (ewe[k]) ref_mem[idx][31-8*k -: 8] = ewd[31-8*k -: 8];
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, wd, x, y, addr_a, addr_b, got_wd;
    logic [3:0]  got_we;
    logic [31:0] resp_rd [3];
    int          acc_cyc [3];
    int          idx, cyc, nresp, ia, ib, ndiff, rst_resp;
    bit          acc;
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    load_mem = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[5] = 32'h8899_AABB;
    repeat (2) @(posedge clk);
    load_mem = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", {21'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wd", bus.mem_wd, 32'd0);
    rst_n = 1'b1;

    run_req(1'b0, 2'd0, 1'b1, 32'h1001_0014, 32'd0, rd, got_we, got_wd);
    check("plan_lb", rd, 32'hFFFF_FF88);
    run_req(1'b0, 2'd0, 1'b0, 32'h1001_0017, 32'd0, rd, got_we, got_wd);
    check("plan_lbu", rd, 32'h0000_00BB);
    run_req(1'b0, 2'd1, 1'b1, 32'h1001_0016, 32'd0, rd, got_we, got_wd);
    check("plan_lh", rd, 32'hFFFF_AABB);
    run_req(1'b0, 2'd1, 1'b0, 32'h1001_0014, 32'd0, rd, got_we, got_wd);
    check("plan_lhu", rd, 32'h0000_8899);
    run_req(1'b0, 2'd2, 1'b0, 32'h1001_0014, 32'd0, rd, got_we, got_wd);
    check("plan_lw", rd, 32'h8899_AABB);
    run_req(1'b1, 2'd1, 1'b0, 32'h1001_0016, 32'h0000_1234, rd, got_we, got_wd);
    check("plan_sh_we", {28'd0, got_we}, 32'h0000_000C);
    check("plan_sh_wd", got_wd, 32'h1234_1234);
    run_req(1'b0, 2'd2, 1'b0, 32'h1001_0014, 32'd0, rd, got_we, got_wd);
    check("plan_lw_after_sh", rd, 32'h8899_1234);
    run_req(1'b1, 2'd0, 1'b0, 32'h1001_0015, 32'h0000_0077, rd, got_we, got_wd);
    check("plan_sb_we", {28'd0, got_we}, 32'h0000_0002);
    check("plan_sb_wd", got_wd, 32'h7777_7777);
    run_req(1'b0, 2'd2, 1'b0, 32'h1001_0014, 32'd0, rd, got_we, got_wd);
    check("plan_lw_after_sb", rd, 32'h8877_1234);

    run_req(1'b0, 2'd2, 1'b0, 32'h1001_0016, 32'd0, rd, got_we, got_wd);
    run_req(1'b0, 2'd1, 1'b0, 32'h1001_0015, 32'd0, rd, got_we, got_wd);
    run_req(1'b0, 2'd3, 1'b0, 32'h1001_0014, 32'd0, rd, got_we, got_wd);
    run_req(1'b0, 2'd2, 1'b0, 32'h1001_2000, 32'd0, rd, got_we, got_wd);
    run_req(1'b0, 2'd2, 1'b0, 32'h1000_FFFC, 32'd0, rd, got_we, got_wd);
    run_req(1'b1, 2'd2, 1'b0, 32'h1001_1FFC, 32'hCAFE_F00D, rd, got_we, got_wd);
    run_req(1'b0, 2'd2, 1'b0, 32'h1001_1FFC, 32'd0, rd, got_we, got_wd);
    check("last_word", rd, 32'hCAFE_F00D);

    // Back-to-back: sw, lw, sw with req_valid held high
    x      = $urandom;
    y      = $urandom;
    addr_a = BASE + 4 * $urandom_range(0, DEPTH - 1);
    addr_b = BASE + 4 * $urandom_range(0, DEPTH - 1);
    ia     = int'((addr_a - BASE) >> 2);
    ib     = int'((addr_b - BASE) >> 2);
    @(negedge clk);
    idx = 0; cyc = 0; nresp = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
    bus.req_signed = 1'b0; bus.req_addr = addr_a; bus.req_wdata = x;
    while (cyc < 20 && (idx < 3 || nresp < 3)) begin
      if (cyc <= 5)
        check($sformatf("b2b_ready_c%0d", cyc), {31'd0, bus.req_ready},
              (cyc == 0 || cyc == 2 || cyc == 5) ? 32'd1 : 32'd0);
      if (bus.resp_valid && nresp < 3) begin
        resp_rd[nresp] = bus.resp_rdata;
        nresp++;
      end
      acc = (idx < 3) && bus.req_ready;
      if (acc) acc_cyc[idx] = cyc;
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx == 1) begin
          bus.req_write = 1'b0; bus.req_addr = addr_a;
        end else if (idx == 2) begin
          bus.req_write = 1'b1; bus.req_addr = addr_b; bus.req_wdata = y;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    check("b2b_nresp", nresp, 32'd3);
    check("b2b_acc0", acc_cyc[0], 32'd0);
    check("b2b_acc1", acc_cyc[1], 32'd2);
    check("b2b_acc2", acc_cyc[2], 32'd5);
    check("b2b_lw_data", resp_rd[1], x);
    ref_mem[ia] = x;
    ref_mem[ib] = y;
    check("b2b_mem_a", tmem[ia], ref_mem[ia]);
    check("b2b_mem_b", tmem[ib], ref_mem[ib]);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE - $urandom_range(1, 64);
      else if (sel == 1) a = BASE + 32'd8192 + $urandom_range(0, 255);
      else               a = BASE + $urandom_range(0, 8191);
      wd = $urandom;
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, wd, rd, got_we, got_wd);
    end

    // Reset during the ACCESS cycle of a store
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 32'h1001_0000; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    check("rst_mid_en_before", {31'd0, bus.mem_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_mid_we", {28'd0, bus.mem_we}, 32'd0);
    check("rst_mid_addr", {21'd0, bus.mem_addr}, 32'd0);
    check("rst_mid_wd", bus.mem_wd, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_rel_ready", {31'd0, bus.req_ready}, 32'd1);
    rst_resp = 0;
    repeat (6) begin
      if (bus.resp_valid) rst_resp++;
      @(negedge clk);
    end
    check("rst_no_resp", rst_resp, 32'd0);
    check("rst_word0", tmem[0], ref_mem[0]);

    ndiff = 0;
    for (int i = 0; i < DEPTH; i++) if (tmem[i] !== ref_mem[i]) ndiff++;
    check("mem_image", ndiff, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
